i2s_rx_core: RTL
================

// Module: i2s_rx_core
// PURPOSE
//  Parametrised I2S / left-justified serial audio receiver. bck, lrck, sdata
//  are treated as asynchronous; they are synchronised into clk and decoded.
//  Each left/right word pair is delivered on a valid/ready interface.
//  Sits between the audio pins and downstream sample FIFOs/DSP in the clk domain.
// PARAMETERS
//  DATA_W       24  output word width per channel, 8..32
//  MODE         0   0 = I2S (MSB one bck after lrck edge), 1 = left-justified (MSB on lrck edge)
//  SYNC_STAGES  2   synchroniser flops on bck/lrck/sdata, >= 2
//  LEFT_LEVEL   0   lrck level that denotes the left channel
// PORTS
//  clk           in   1       system clock; must be >= 4x bck frequency
//  reset         in   1       synchronous, active-high
//  enable        in   1       1 = capture; 0 = capture FSM idle
//  bck           in   1       async bit clock
//  lrck          in   1       async channel select
//  sdata         in   1       async serial data, MSB first
//  sample_left   out  DATA_W  left word, MSB-aligned
//  sample_right  out  DATA_W  right word, MSB-aligned
//  sample_valid  out  1       pair available
//  sample_ready  in   1       consumer accepts pair
//  overflow      out  1       1-cycle pulse: completed pair dropped
// BEHAVIOUR
//  Reset: all outputs 0; synchroniser flops, lrck_prev, counters, holding regs,
//   slot_active, left_hold_valid, and pending_start all cleared.
//  Sync: bck, lrck, sdata each pass through SYNC_STAGES flops.
//   bck_rise = bck_s & ~bck_s_d. On bck_rise, sample lrck_s and sdata_s.
//   lrck_prev updates only on bck_rise. Pin-to-bck_rise latency = SYNC_STAGES+1 clk.
//  Transition: on bck_rise, lrck_s != lrck_prev.
//  Slot start:
//   MODE=1: at the transition rise.
//   MODE=0: the bit at the transition rise belongs to the old slot; set pending_start.
//    The next bck_rise is the slot start.
//  At slot start (one clk cycle, same bck_rise):
//   1) If slot_active, commit the old word.
//   2) word <= {bit, zeros}; cnt <= 1; chan <= (lrck == LEFT_LEVEL) ? L : R;
//      slot_active <= 1.
//  Other bck_rise with slot_active:
//   - If cnt < DATA_W: word[DATA_W-1-cnt] <= bit; cnt++.
//   - Otherwise the bit is ignored; longer slots are truncated.
//   - Shorter slots leave zero LSBs.
//  Partial slots: after reset or enable rise, slot_active=0 until the first slot start.
//   The partial slot is never committed.
//  Commit L: left_hold <= word; left_hold_valid <= 1. A second L overwrites.
//  Commit R:
//   - left_hold_valid=0: the word is discarded.
//   - left_hold_valid=1: pair complete; left_hold_valid <= 0.
//  Pair complete:
//   - If !sample_valid | sample_ready: load sample_left/right; sample_valid=1 next clk.
//   - Otherwise: outputs unchanged; overflow=1 for one clk.
//   - Completion in the same cycle as an accepting handshake loads the new pair
//     and keeps sample_valid=1.
//  Handshake: transfer when sample_valid & sample_ready.
//   sample_valid clears next clk unless a new pair loads in the same cycle.
//   Data is stable while valid & !ready.
//  enable=0:
//   - slot_active, pending_start, left_hold_valid cleared next clk.
//   - Synchronisers, lrck_prev, and the output handshake keep running.
//   - A pending output pair is retained.
//  Reset mid-slot: state returns to reset values; the partial slot is discarded as above.
// TESTING
//  1 MODE=0, DATA_W=24, 24-bit slots, bck=clk/8, ready=1, L=0xA5A5A5 R=0x5A5A5A x3 frames
//    -> first frame dropped (partial); later frames -> sample_left=0xA5A5A5,
//       sample_right=0x5A5A5A, valid 1 clk per frame.
//  2 32-bit slots, DATA_W=24, L=0x123456FF R=0x89ABCDEE -> 0x123456 / 0x89ABCD.
//  3 16-bit slots, DATA_W=24, L=0xBEEF R=0x0001 -> 0xBEEF00 / 0x000100.
//  4 ready=0 over two complete frames -> first pair held stable, overflow pulses once;
//    then ready=1 -> first pair transfers, valid drops.
//  5 reset=1 for 1 clk mid right slot -> all outputs 0 next clk; next full pair correct;
//    no overflow.
//  6 MODE=1, data as test 1 with MSB on the lrck-edge rise -> same values;
//    MODE=0 stimulus into MODE=1 DUT -> words shifted 1 bit (negative check).

Source files
------------

// File: rtl/i2s_rx_core.sv
// i2s_rx_core: I2S / left-justified serial audio receiver.
// bck, lrck and sdata arrive asynchronously. They are synchronised into clk,
// decoded into per-channel words, and paired left/right words are handed
// downstream on a valid/ready interface.
module i2s_rx_core #(
   parameter int   DATA_W      = 24,
   parameter int   MODE        = 0,
   parameter int   SYNC_STAGES = 2,
   parameter logic LEFT_LEVEL  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              bck,
   input  logic              lrck,
   input  logic              sdata,
   output logic [DATA_W-1:0] sample_left,
   output logic [DATA_W-1:0] sample_right,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overflow
);

   localparam int                CNT_W     = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] MSB_ONE   = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [SYNC_STAGES-1:0] SYNC_ZERO = {SYNC_STAGES{1'b0}};
   // Left-justified: the MSB sits on the lrck edge itself.
   localparam logic              LJ_MODE   = (MODE == 1);

   // synchroniser chains and edge detection
   logic [SYNC_STAGES-1:0] bck_sync_r;
   logic [SYNC_STAGES-1:0] lrck_sync_r;
   logic [SYNC_STAGES-1:0] sdata_sync_r;
   logic                   bck_prev_r;
   logic                   lrck_prev_r;

   // slot capture state
   logic                   pending_start_r;
   logic                   slot_active_r;
   logic [DATA_W-1:0]      word_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   chan_left_r;

   // left word waiting for its right partner, and the output stage
   logic [DATA_W-1:0]      left_hold_r;
   logic                   left_hold_valid_r;
   logic [DATA_W-1:0]      sample_left_r;
   logic [DATA_W-1:0]      sample_right_r;
   logic                   sample_valid_r;
   logic                   overflow_r;

   logic bck_s;
   logic lrck_s;
   logic sdata_s;
   logic bck_rise_s;
   logic transition_s;
   logic slot_start_s;
   logic commit_s;
   logic commit_left_s;
   logic commit_right_s;
   logic pair_done_s;
   logic accept_s;

   // Decode bit-clock rises, channel transitions and slot boundaries.
   always_comb begin
      bck_s        = bck_sync_r[SYNC_STAGES-1];
      lrck_s       = lrck_sync_r[SYNC_STAGES-1];
      sdata_s      = sdata_sync_r[SYNC_STAGES-1];
      bck_rise_s   = bck_s & ~bck_prev_r;
      transition_s = bck_rise_s & (lrck_s != lrck_prev_r);
      if (LJ_MODE) begin
         slot_start_s = transition_s & enable;
      end else begin
         // I2S: the rise after the lrck change carries the new MSB.
         slot_start_s = bck_rise_s & pending_start_r & enable;
      end
      commit_s       = slot_start_s & slot_active_r;
      commit_left_s  = commit_s & chan_left_r;
      commit_right_s = commit_s & ~chan_left_r;
      pair_done_s    = commit_right_s & left_hold_valid_r;
      accept_s       = ~sample_valid_r | sample_ready;
   end

   // Synchronise the pins and track the previous bck and sampled lrck levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         bck_sync_r   <= SYNC_ZERO;
         lrck_sync_r  <= SYNC_ZERO;
         sdata_sync_r <= SYNC_ZERO;
         bck_prev_r   <= 1'b0;
         lrck_prev_r  <= 1'b0;
      end else begin
         bck_sync_r   <= {bck_sync_r[SYNC_STAGES-2:0], bck};
         lrck_sync_r  <= {lrck_sync_r[SYNC_STAGES-2:0], lrck};
         sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], sdata};
         bck_prev_r   <= bck_s;
         if (bck_rise_s) begin
            lrck_prev_r <= lrck_s;
         end
      end
   end

   // Shift serial bits MSB-first into the current slot word.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_start_r <= 1'b0;
         slot_active_r   <= 1'b0;
         word_r          <= WORD_ZERO;
         cnt_r           <= CNT_ZERO;
         chan_left_r     <= 1'b0;
      end else if (!enable) begin
         // Idle until a fresh slot start so no partial slot is ever committed.
         pending_start_r <= 1'b0;
         slot_active_r   <= 1'b0;
      end else if (bck_rise_s) begin
         pending_start_r <= transition_s & ~LJ_MODE;
         if (slot_start_s) begin
            word_r        <= sdata_s ? MSB_ONE : WORD_ZERO;
            cnt_r         <= CNT_ONE;
            chan_left_r   <= (lrck_s == LEFT_LEVEL);
            slot_active_r <= 1'b1;
         end else if (slot_active_r && (cnt_r < CNT_MAX)) begin
            // Word starts zeroed, so only one-bits need writing; bits past
            // DATA_W fall through this branch and are dropped.
            if (sdata_s) begin
               word_r <= word_r | (MSB_ONE >> cnt_r);
            end
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // Hold the committed left word until its right partner arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         left_hold_r       <= WORD_ZERO;
         left_hold_valid_r <= 1'b0;
      end else if (!enable) begin
         left_hold_valid_r <= 1'b0;
      end else if (commit_left_s) begin
         left_hold_r       <= word_r;
         left_hold_valid_r <= 1'b1;
      end else if (commit_right_s) begin
         left_hold_valid_r <= 1'b0;
      end
   end

   // Output register with valid/ready handshake and overflow on a dropped pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_left_r  <= WORD_ZERO;
         sample_right_r <= WORD_ZERO;
         sample_valid_r <= 1'b0;
         overflow_r     <= 1'b0;
      end else if (pair_done_s && accept_s) begin
         sample_left_r  <= left_hold_r;
         sample_right_r <= word_r;
         sample_valid_r <= 1'b1;
         overflow_r     <= 1'b0;
      end else if (pair_done_s) begin
         // Consumer still owns the old pair: keep it stable, drop the new one.
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= 1'b0;
         if (sample_valid_r && sample_ready) begin
            sample_valid_r <= 1'b0;
         end
      end
   end

   assign sample_left  = sample_left_r;
   assign sample_right = sample_right_r;
   assign sample_valid = sample_valid_r;
   assign overflow     = overflow_r;

endmodule
